// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for the IF stage.
// Owns the fetch PC, keeps exactly one request outstanding to instruction
// memory, and presents one fetched instruction on if_pc/if_inst. Handles the
// delayed-branch redirect from ID, exception flush, and drops stale responses
// that belong to a request issued before a flush.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_from_if
);

  // START: first request after reset; FETCH: waiting on our own request;
  // READY: instruction presented; DISCARD: waiting on a pre-flush request.
  typedef enum logic [1:0] {
    START   = 2'd0,
    FETCH   = 2'd1,
    READY   = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        inst_req_q, inst_req_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        pend_br_q, pend_br_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic        ack_v;
  logic        br_cap;
  logic        consume;
  logic [31:0] pc_next;

  // Only stall[1] (IF) and stall[2] (ID) matter to this stage.
  logic unused_stall;
  assign unused_stall = &{1'b0, stall[5:3], stall[0]};

  // An ack only counts while our request is actually up.
  assign ack_v   = inst_ack & inst_req_q;
  // ID holds a taken branch and is advancing this edge.
  assign br_cap  = branch_flag_i & ~stall[2];
  // Presented instruction leaves IF this edge.
  assign consume = (state_q == READY) & ~stall[1];

  // A branch captured on the consume edge itself redirects immediately;
  // otherwise a pending target wins over sequential PC (wraps mod 2^32).
  always_comb begin
    pc_next = if_pc_q + 32'd4;
    if (br_cap)         pc_next = branch_target_address_i;
    else if (pend_br_q) pc_next = pend_tgt_q;
  end

  // Next-state and register updates; flush overrides everything else.
  always_comb begin
    state_d     = state_q;
    inst_req_d  = inst_req_q;
    inst_addr_d = inst_addr_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    pend_br_d   = pend_br_q;
    pend_tgt_d  = pend_tgt_q;

    if (br_cap) begin
      pend_br_d  = 1'b1;
      pend_tgt_d = branch_target_address_i;
    end

    if (flush) begin
      pc_d      = new_pc;
      pend_br_d = 1'b0;
      case (state_q)
        START: begin
          state_d     = FETCH;
          inst_req_d  = 1'b1;
          inst_addr_d = new_pc;
        end
        FETCH: begin
          // Response to the old address is dropped either way; if it already
          // arrived the new request can go out right away.
          if (ack_v) inst_addr_d = new_pc;
          else       state_d     = DISCARD;
        end
        READY: begin
          state_d     = FETCH;
          inst_req_d  = 1'b1;
          inst_addr_d = new_pc;
        end
        DISCARD: begin
          if (ack_v) begin
            state_d     = FETCH;
            inst_addr_d = new_pc;
          end
        end
        default: state_d = START;
      endcase
    end else begin
      case (state_q)
        START: begin
          state_d     = FETCH;
          inst_req_d  = 1'b1;
          inst_addr_d = pc_q;
        end
        FETCH: begin
          if (ack_v) begin
            state_d    = READY;
            inst_req_d = 1'b0;
            if_pc_d    = inst_addr_q;
            if_inst_d  = inst_rdata;
          end
        end
        READY: begin
          if (consume) begin
            state_d     = FETCH;
            inst_req_d  = 1'b1;
            inst_addr_d = pc_next;
            pc_d        = pc_next;
            pend_br_d   = 1'b0;
          end
        end
        DISCARD: begin
          // Stale response arrives: drop it and fetch from the flush target.
          if (ack_v) begin
            state_d     = FETCH;
            inst_addr_d = pc_q;
          end
        end
        default: state_d = START;
      endcase
    end
  end

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= START;
      inst_req_q  <= 1'b0;
      inst_addr_q <= 32'h0;
      pc_q        <= RESET_PC;
      if_pc_q     <= 32'h0;
      if_inst_q   <= 32'h0;
      pend_br_q   <= 1'b0;
      pend_tgt_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      inst_req_q  <= inst_req_d;
      inst_addr_q <= inst_addr_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      pend_br_q   <= pend_br_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  assign inst_req         = inst_req_q;
  assign inst_addr        = inst_addr_q;
  assign if_pc            = if_pc_q;
  assign if_inst          = if_inst_q;
  assign stallreq_from_if = (state_q != READY);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small wait-state memory model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall = 6'd0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = 32'h0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_from_if;

  int nchk = 0;
  int npass = 0;
  int mem_wait = 0;
  int cnt = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rdata(inst_rdata), .if_pc(if_pc), .if_inst(if_inst),
    .stallreq_from_if(stallreq_from_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Memory: acks once the request has been up for mem_wait edges.
  always @(posedge clk) begin
    if (!inst_req || inst_ack) cnt <= 0;
    else                       cnt <= cnt + 1;
  end
  assign inst_ack   = inst_req && (cnt >= mem_wait);
  assign inst_rdata = dat(inst_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    nchk++;
    if ({inst_req, inst_addr, if_pc, if_inst, stallreq_from_if} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b1})
      $display("FAIL reset_vals: got req=%b addr=%h pc=%h inst=%h sr=%b want 0 0 0 0 1",
               inst_req, inst_addr, if_pc, if_inst, stallreq_from_if);
    else npass++;
    tick();
    nchk++;
    if ({inst_req, stallreq_from_if} !== 2'b01)
      $display("FAIL reset_hold: got req=%b sr=%b want 0 1", inst_req, stallreq_from_if);
    else npass++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    mem_wait = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      nchk++;
      if ({inst_req, inst_addr, stallreq_from_if} !== {1'b1, 32'(4*k), 1'b1})
        $display("FAIL zw_fetch%0d: got req=%b addr=%h sr=%b want 1 %h 1",
                 k, inst_req, inst_addr, stallreq_from_if, 32'(4*k));
      else npass++;
      tick();
      nchk++;
      if ({inst_req, if_pc, if_inst, stallreq_from_if} !== {1'b0, 32'(4*k), dat(32'(4*k)), 1'b0})
        $display("FAIL zw_ready%0d: got req=%b pc=%h inst=%h sr=%b want 0 %h %h 0",
                 k, inst_req, if_pc, if_inst, stallreq_from_if, 32'(4*k), dat(32'(4*k)));
      else npass++;
    end
  endtask

  task automatic test_wait_states();
    mem_wait = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      nchk++;
      if ({inst_req, inst_addr, stallreq_from_if} !== {1'b1, 32'h10, 1'b1})
        $display("FAIL ws_hold%0d: got req=%b addr=%h sr=%b want 1 00000010 1",
                 i, inst_req, inst_addr, stallreq_from_if);
      else npass++;
    end
    tick();
    nchk++;
    if ({inst_req, if_pc, if_inst, stallreq_from_if} !== {1'b0, 32'h10, dat(32'h10), 1'b0})
      $display("FAIL ws_ready: got req=%b pc=%h inst=%h sr=%b want 0 00000010 %h 0",
               inst_req, if_pc, if_inst, stallreq_from_if, dat(32'h10));
    else npass++;
  endtask

  task automatic test_stall();
    stall = 6'b000010;
    for (int i = 0; i < 5; i++) begin
      tick();
      nchk++;
      if ({inst_req, if_pc, if_inst, stallreq_from_if} !== {1'b0, 32'h10, dat(32'h10), 1'b0})
        $display("FAIL stall_hold%0d: got req=%b pc=%h inst=%h sr=%b want 0 00000010 %h 0",
                 i, inst_req, if_pc, if_inst, stallreq_from_if, dat(32'h10));
      else npass++;
    end
    mem_wait = 1;
    stall = 6'd0;
    tick();
    nchk++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h14})
      $display("FAIL stall_release: got req=%b addr=%h want 1 00000014", inst_req, inst_addr);
    else npass++;
    tick();
    tick();
    nchk++;
    if (if_pc !== 32'h14) $display("FAIL stall_next_ready: got pc=%h want 00000014", if_pc);
    else npass++;
  endtask

  task automatic test_branch();
    flush = 1'b1; new_pc = 32'h20;
    tick();
    nchk++;
    if ({inst_req, inst_addr, stallreq_from_if} !== {1'b1, 32'h20, 1'b1})
      $display("FAIL br_slot_fetch: got req=%b addr=%h sr=%b want 1 00000020 1",
               inst_req, inst_addr, stallreq_from_if);
    else npass++;
    flush = 1'b0;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    tick();
    branch_flag_i = 1'b0;
    tick();
    nchk++;
    if ({if_pc, stallreq_from_if} !== {32'h20, 1'b0})
      $display("FAIL br_slot_ready: got pc=%h sr=%b want 00000020 0", if_pc, stallreq_from_if);
    else npass++;
    tick();
    nchk++;
    if (inst_addr !== 32'h100) $display("FAIL br_target: got addr=%h want 00000100", inst_addr);
    else npass++;
    tick(); tick();
    tick();
    nchk++;
    if (inst_addr !== 32'h104) $display("FAIL br_cleared: got addr=%h want 00000104", inst_addr);
    else npass++;
    // Capture on the consume edge redirects straight away.
    tick(); tick();
    branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
    tick();
    branch_flag_i = 1'b0;
    nchk++;
    if (inst_addr !== 32'h200) $display("FAIL br_same_edge: got addr=%h want 00000200", inst_addr);
    else npass++;
    tick(); tick();
    tick();
    nchk++;
    if (inst_addr !== 32'h204) $display("FAIL br_same_edge_clr: got addr=%h want 00000204", inst_addr);
    else npass++;
    // ID stalled: branch must not be captured.
    branch_flag_i = 1'b1; branch_target_address_i = 32'h300; stall = 6'b000100;
    tick();
    branch_flag_i = 1'b0; stall = 6'd0;
    tick();
    tick();
    nchk++;
    if (inst_addr !== 32'h208) $display("FAIL br_id_stalled: got addr=%h want 00000208", inst_addr);
    else npass++;
    tick(); tick();
  endtask

  task automatic test_flush();
    mem_wait = 3;
    flush = 1'b1; new_pc = 32'h40;
    tick();
    flush = 1'b0;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h500;
    tick();
    branch_flag_i = 1'b0;
    flush = 1'b1; new_pc = 32'h380;
    tick();
    flush = 1'b0;
    nchk++;
    if ({inst_req, inst_addr, stallreq_from_if} !== {1'b1, 32'h40, 1'b1})
      $display("FAIL fl_discard: got req=%b addr=%h sr=%b want 1 00000040 1",
               inst_req, inst_addr, stallreq_from_if);
    else npass++;
    tick();
    nchk++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h40})
      $display("FAIL fl_discard_hold: got req=%b addr=%h want 1 00000040", inst_req, inst_addr);
    else npass++;
    tick();
    nchk++;
    if ({inst_req, inst_addr, if_pc, stallreq_from_if} !== {1'b1, 32'h380, 32'h208, 1'b1})
      $display("FAIL fl_redirect: got req=%b addr=%h pc=%h sr=%b want 1 00000380 00000208 1",
               inst_req, inst_addr, if_pc, stallreq_from_if);
    else npass++;
    tick(); tick(); tick();
    tick();
    nchk++;
    if ({if_pc, if_inst, stallreq_from_if} !== {32'h380, dat(32'h380), 1'b0})
      $display("FAIL fl_ready: got pc=%h inst=%h sr=%b want 00000380 %h 0",
               if_pc, if_inst, stallreq_from_if, dat(32'h380));
    else npass++;
    tick();
    nchk++;
    if (inst_addr !== 32'h384) $display("FAIL fl_pend_cleared: got addr=%h want 00000384", inst_addr);
    else npass++;
  endtask

  task automatic test_wrap_and_reset();
    mem_wait = 0;
    tick();
    tick();
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    nchk++;
    if ({inst_req, inst_addr, if_pc, stallreq_from_if} !== {1'b1, 32'hFFFF_FFFC, 32'h384, 1'b1})
      $display("FAIL fl_ack_edge: got req=%b addr=%h pc=%h sr=%b want 1 fffffffc 00000384 1",
               inst_req, inst_addr, if_pc, stallreq_from_if);
    else npass++;
    tick();
    nchk++;
    if (if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_ready: got pc=%h want fffffffc", if_pc);
    else npass++;
    tick();
    nchk++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h0})
      $display("FAIL wrap_addr: got req=%b addr=%h want 1 00000000", inst_req, inst_addr);
    else npass++;
    #2 rst = 1'b1;
    #1;
    nchk++;
    if ({inst_req, inst_addr, if_pc, if_inst, stallreq_from_if} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b1})
      $display("FAIL async_reset: got req=%b addr=%h pc=%h inst=%h sr=%b want 0 0 0 0 1",
               inst_req, inst_addr, if_pc, if_inst, stallreq_from_if);
    else npass++;
    @(negedge clk) rst = 1'b0;
    tick();
    nchk++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h0})
      $display("FAIL restart: got req=%b addr=%h want 1 00000000", inst_req, inst_addr);
    else npass++;
    tick();
    nchk++;
    if ({if_pc, if_inst, stallreq_from_if} !== {32'h0, dat(32'h0), 1'b0})
      $display("FAIL restart_ready: got pc=%h inst=%h sr=%b want 0 %h 0",
               if_pc, if_inst, stallreq_from_if, dat(32'h0));
    else npass++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_branch();
    test_flush();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch producer for the IF stage. Generates the fetch PC and runs a single-outstanding req/ack handshake to instruction memory.
- Presents one fetched instruction on if_pc/if_inst for the IF/ID pipeline register to capture.
- Raises stallreq_from_if whenever no valid instruction is ready.
- Handles delayed-branch redirect and exception flush, and discards stale memory responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  6  pipeline stall vector from ctrl; bit1 = IF stage stalled, bit2 = ID stage stalled; other bits ignored
flush  in  1  exception flush
new_pc  in  32  flush redirect target
branch_flag_i  in  1  branch taken, from ID
branch_target_address_i  in  32  branch target, from ID
inst_req  out  1  fetch request
inst_addr  out  32  fetch address
inst_ack  in  1  memory response valid; data on inst_rdata
inst_rdata  in  32  fetched instruction word
if_pc  out  32  PC of presented instruction
if_inst  out  32  presented instruction
stallreq_from_if  out  1  asserted = no valid instruction ready (ctrl stalls PC/IF and bubbles ID)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. All registers reset immediately on rst.
- Reset values:
  - state = START, inst_req = 0, inst_addr = 0, pc = RESET_PC
  - if_pc = 0, if_inst = 0
  - pend_br = 0, pend_tgt = 0
  - stallreq_from_if = 1
- Reset asserted mid-transaction abandons any outstanding request. Memory must tolerate this.
- stallreq_from_if = (state != READY), combinational.
- States: START, FETCH, READY, DISCARD.
  - START: next edge -> FETCH, inst_req <= 1, inst_addr <= pc.
  - FETCH: inst_req held at 1 and inst_addr held stable until an edge samples inst_ack = 1.
    - On ack: if_pc <= inst_addr, if_inst <= inst_rdata, inst_req <= 0, -> READY.
    - Ack may be sampled in the same cycle req first rises. Minimum latency is req rise to READY = 1 edge.
  - READY: if_pc/if_inst held.
    - Consumed at an edge with stall[1] = 0.
    - On consume: pc_next = pend_br ? pend_tgt : if_pc + 4; clear pend_br; inst_addr <= pc_next, inst_req <= 1, -> FETCH.
    - stall[1] = 1: hold indefinitely.
  - DISCARD: an older request is still outstanding. Keep inst_req = 1 and the old inst_addr.
    - On ack: drop data, inst_addr <= pc, -> FETCH.
- Delayed branch:
  - At any edge with branch_flag_i = 1 and stall[2] = 0, capture pend_br <= 1 and pend_tgt <= branch_target_address_i.
  - The target is applied at the next consume (the delay slot is consumed first), then pend_br clears.
  - If capture and consume occur at the same edge, the newly captured target is used directly.
- Flush has highest priority at any edge with flush = 1:
  - pc <= new_pc; pend_br <= 0.
  - FETCH with no ack this edge -> DISCARD.
  - FETCH with ack this edge -> data dropped, inst_addr <= new_pc, inst_req <= 1, stay FETCH.
  - READY -> buffered instruction dropped, inst_addr <= new_pc, inst_req <= 1, -> FETCH.
  - DISCARD -> stay DISCARD (or -> FETCH at new_pc if acked this edge).
  - START -> pc updated, then normal START behaviour.
- Arithmetic: pc + 4 is modulo 2^32 (32'hFFFF_FFFC -> 0). Targets are taken as-is; no alignment check.
- Exactly one request is outstanding at a time. inst_ack while inst_req = 0 is ignored.

Test Plan:
- Reset release, zero-wait memory (ack same cycle), stall = 0 -> inst_addr sequence 0, 4, 8, … one new address every 2 cycles; if_pc matches; stallreq_from_if toggles 1/0.
- 3-wait-state ack on address 0x10 -> inst_req and inst_addr = 0x10 stable 4 cycles; READY with if_inst = ack data; stallreq_from_if low only in READY.
- Branch at ID while delay slot 0x20 is in FETCH: branch_flag_i = 1 (stall[2] = 0), target 0x100 -> delay slot 0x20 presented, then next fetch address = 0x100, not 0x24.
- flush with new_pc = 0x380 while request to 0x40 is outstanding (ack 2 cycles later) -> DISCARD holds 0x40 until ack; data dropped; next request 0x380; pend_br cleared.
- READY with stall[1] = 1 for 5 cycles -> outputs and inst_req = 0 held; release -> next address = if_pc + 4.
- if_pc = 0xFFFF_FFFC consumed -> next inst_addr = 0; rst asserted during FETCH -> outputs return to reset values immediately, without waiting for clk.
